// File: rtl/prbs7_checker.sv
// PRBS7 (x^7+x^6+1) word checker: self-synchronises to the incoming stream, then free-runs its own
// reference and reports per-word bit errors plus saturating error/word counters.
module prbs7_checker #(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned TAP1       = 6,
    parameter int unsigned TAP2       = 5,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       din_valid,
    input  logic [WIDTH-1:0]           din,
    input  logic                       clr_cnt,
    output logic                       locked,
    output logic                       err_word,
    output logic [$clog2(WIDTH+1)-1:0] err_bits,
    output logic [CNT_W-1:0]           err_cnt,
    output logic [CNT_W-1:0]           word_cnt
);

    localparam int unsigned EB_W  = $clog2(WIDTH + 1);
    localparam int unsigned MC_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned BC_W  = $clog2(UNLOCK_CNT + 1);
    localparam int unsigned SUM_W = ((CNT_W > EB_W) ? CNT_W : EB_W) + 1;

    typedef enum logic [0:0] {StSearch, StLocked} state_e;

    state_e            state_q;
    logic              seed_vld_q;
    logic [WIDTH-1:0]  seed_q;
    logic [WIDTH-1:0]  ref_q;
    logic [MC_W-1:0]   match_cnt_q;
    logic [BC_W-1:0]   bad_cnt_q;

    logic [WIDTH-1:0]  seed_nxt;
    logic [WIDTH-1:0]  din_nxt;
    logic [WIDTH-1:0]  ref_nxt;
    logic [WIDTH-1:0]  err_vec;
    logic [EB_W-1:0]   err_pop;
    logic              din_match;
    logic [SUM_W-1:0]  err_sum;
    logic [CNT_W-1:0]  err_cnt_sat;
    logic [CNT_W-1:0]  word_cnt_sat;

    // Advance the LFSR one full word: WIDTH single-bit shifts.
    function automatic logic [WIDTH-1:0] prbs_next(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] s;
        s = x;
        for (int i = 0; i < int'(WIDTH); i++) begin
            s = {s[WIDTH-2:0], s[TAP1] ^ s[TAP2]};
        end
        return s;
    endfunction

    function automatic logic [EB_W-1:0] popcount(input logic [WIDTH-1:0] x);
        logic [EB_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            n = n + EB_W'(x[i]);
        end
        return n;
    endfunction

    always_comb begin
        seed_nxt     = prbs_next(seed_q);
        din_nxt      = prbs_next(din);
        ref_nxt      = prbs_next(ref_q);
        err_vec      = din ^ ref_q;
        err_pop      = popcount(err_vec);
        // All-zero is the LFSR's stuck state and must never build confidence.
        din_match    = (din == seed_nxt) && (din != '0);
        err_sum      = SUM_W'(err_cnt) + SUM_W'(err_pop);
        err_cnt_sat  = (err_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : err_sum[CNT_W-1:0];
        word_cnt_sat = (&word_cnt) ? word_cnt : word_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StSearch;
            seed_vld_q  <= 1'b0;
            seed_q      <= '0;
            ref_q       <= '0;
            match_cnt_q <= '0;
            bad_cnt_q   <= '0;
            locked      <= 1'b0;
            err_word    <= 1'b0;
            err_bits    <= '0;
            err_cnt     <= '0;
            word_cnt    <= '0;
        end else begin
            err_word <= 1'b0;
            err_bits <= '0;
            if (din_valid) begin
                unique case (state_q)
                    StSearch: begin
                        seed_q     <= din;
                        seed_vld_q <= 1'b1;
                        if (seed_vld_q) begin
                            if (!din_match) begin
                                match_cnt_q <= '0;
                            end else if (match_cnt_q == MC_W'(LOCK_CNT - 1)) begin
                                state_q     <= StLocked;
                                locked      <= 1'b1;
                                ref_q       <= din_nxt;
                                bad_cnt_q   <= '0;
                                match_cnt_q <= '0;
                            end else begin
                                match_cnt_q <= match_cnt_q + MC_W'(1);
                            end
                        end
                    end
                    StLocked: begin
                        // Reference free-runs so a single flipped bit costs exactly one error.
                        ref_q    <= ref_nxt;
                        err_bits <= err_pop;
                        err_word <= (err_vec != '0);
                        err_cnt  <= err_cnt_sat;
                        word_cnt <= word_cnt_sat;
                        if (err_vec == '0) begin
                            bad_cnt_q <= '0;
                        end else if (bad_cnt_q == BC_W'(UNLOCK_CNT - 1)) begin
                            state_q     <= StSearch;
                            locked      <= 1'b0;
                            seed_q      <= din;
                            seed_vld_q  <= 1'b1;
                            match_cnt_q <= '0;
                            bad_cnt_q   <= '0;
                        end else begin
                            bad_cnt_q <= bad_cnt_q + BC_W'(1);
                        end
                    end
                    default: state_q <= StSearch;
                endcase
            end
            if (clr_cnt) begin
                err_cnt  <= '0;
                word_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker: table of directed vectors on a 32-bit-counter instance, plus hand
// sequences for stuck/random input, counter saturation on a 4-bit-counter instance and reset.
module tb_prbs7_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din_valid = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [23:0] din = '0;

    logic        locked, err_word;
    logic [4:0]  err_bits;
    logic [31:0] err_cnt, word_cnt;
    logic        locked4, err_word4;
    logic [4:0]  err_bits4;
    logic [3:0]  err_cnt4, word_cnt4;

    int checks = 0;
    int failures = 0;

    logic [23:0] g[64];
    localparam logic [23:0] ALL = 24'hFFFFFF;
    localparam logic [23:0] IDL = 24'h5A5A5A;

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic [23:0] din;
        logic        clr;
        logic        exp_locked;
        logic        exp_err_word;
        logic [4:0]  exp_err_bits;
        logic [31:0] exp_err_cnt;
        logic [31:0] exp_word_cnt;
    } vec_t;

    vec_t vecs[$];

    prbs7_checker #(.WIDTH(24), .TAP1(6), .TAP2(5), .LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
        .locked(locked), .err_word(err_word), .err_bits(err_bits),
        .err_cnt(err_cnt), .word_cnt(word_cnt)
    );

    prbs7_checker #(.WIDTH(24), .TAP1(6), .TAP2(5), .LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
        .locked(locked4), .err_word(err_word4), .err_bits(err_bits4),
        .err_cnt(err_cnt4), .word_cnt(word_cnt4)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] gen_next(input logic [23:0] x);
        logic [23:0] s;
        s = x;
        for (int i = 0; i < 24; i++) s = {s[22:0], s[6] ^ s[5]};
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [23:0] d, input logic c);
        rst_n = r;
        din_valid = v;
        din = d;
        clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic v, input logic [23:0] d, input logic c,
                       input logic l, input logic ew, input int eb, input int ec, input int wc);
        vec_t t;
        t.rst_n = r; t.valid = v; t.din = d; t.clr = c;
        t.exp_locked = l; t.exp_err_word = ew; t.exp_err_bits = 5'(eb);
        t.exp_err_cnt = 32'(ec); t.exp_word_cnt = 32'(wc);
        vecs.push_back(t);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic seen_lock;
        logic seen_err;

        g[0] = 24'h000001;
        for (int k = 1; k < 64; k++) g[k] = gen_next(g[k-1]);

        // Lock, single-bit error, idle, clear, three fully-errored words, relock.
        add(0, 0, IDL, 0, 0, 0, 0, 0, 0);
        add(0, 0, IDL, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) add(1, 1, g[k], 0, 0, 0, 0, 0, 0);
        add(1, 1, g[5], 0, 1, 0, 0, 0, 0);
        add(1, 1, g[6], 0, 1, 0, 0, 0, 1);
        add(1, 1, g[7], 0, 1, 0, 0, 0, 2);
        add(1, 1, g[8] ^ 24'h1, 0, 1, 1, 1, 1, 3);
        add(1, 0, IDL, 0, 1, 0, 0, 1, 3);
        add(1, 1, g[9], 0, 1, 0, 0, 1, 4);
        add(1, 1, g[10], 0, 1, 0, 0, 1, 5);
        add(1, 0, IDL, 1, 1, 0, 0, 0, 0);
        add(1, 1, g[11] ^ ALL, 0, 1, 1, 24, 24, 1);
        add(1, 1, g[12] ^ ALL, 0, 1, 1, 24, 48, 2);
        add(1, 1, g[13] ^ ALL, 0, 0, 1, 24, 72, 3);
        for (int k = 14; k <= 17; k++) add(1, 1, g[k], 0, 0, 0, 0, 72, 3);
        add(1, 1, g[18], 0, 1, 0, 0, 72, 3);
        add(1, 1, g[19], 0, 1, 0, 0, 72, 4);
        // Reset mid-lock, then a gapped valid stream.
        add(0, 1, g[20], 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            add(1, 1, g[k], 0, 0, 0, 0, 0, 0);
            add(1, 0, IDL, 0, 0, 0, 0, 0, 0);
        end
        add(1, 1, g[5], 0, 1, 0, 0, 0, 0);
        add(1, 0, IDL, 0, 1, 0, 0, 0, 0);
        add(1, 1, g[6], 0, 1, 0, 0, 0, 1);
        add(1, 0, IDL, 0, 1, 0, 0, 0, 1);
        add(1, 1, g[7], 0, 1, 0, 0, 0, 2);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].valid, vecs[i].din, vecs[i].clr);
            chk($sformatf("v%0d locked", i), 32'(locked), 32'(vecs[i].exp_locked));
            chk($sformatf("v%0d err_word", i), 32'(err_word), 32'(vecs[i].exp_err_word));
            chk($sformatf("v%0d err_bits", i), 32'(err_bits), 32'(vecs[i].exp_err_bits));
            chk($sformatf("v%0d err_cnt", i), err_cnt, vecs[i].exp_err_cnt);
            chk($sformatf("v%0d word_cnt", i), word_cnt, vecs[i].exp_word_cnt);
        end

        // Stuck-at-zero and random data must never lock or count.
        drive(0, 0, IDL, 0);
        seen_lock = 1'b0;
        seen_err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            drive(1, 1, 24'h0, 0);
            seen_lock |= locked;
            seen_err |= err_word;
        end
        for (int i = 0; i < 60; i++) begin
            drive(1, 1, 24'($urandom()), 0);
            seen_lock |= locked;
            seen_err |= err_word;
        end
        chk("noise locked_seen", 32'(seen_lock), 0);
        chk("noise err_word_seen", 32'(seen_err), 0);
        chk("noise err_cnt", err_cnt, 0);
        chk("noise word_cnt", word_cnt, 0);

        // Saturation on the 4-bit counter instance, clear vs same-cycle error, reset while locked.
        drive(0, 0, IDL, 0);
        for (int k = 1; k <= 5; k++) drive(1, 1, g[k], 0);
        chk("sat locked4", 32'(locked4), 1);
        for (int k = 6; k <= 25; k++) drive(1, 1, g[k], 0);
        chk("sat word_cnt", word_cnt, 20);
        chk("sat word_cnt4", 32'(word_cnt4), 15);
        chk("sat err_cnt4 clean", 32'(err_cnt4), 0);
        drive(1, 1, g[26] ^ ALL, 0);
        chk("sat err_cnt first", err_cnt, 24);
        chk("sat err_cnt4 first", 32'(err_cnt4), 15);
        drive(1, 1, g[27] ^ ALL, 0);
        chk("sat err_cnt second", err_cnt, 48);
        chk("sat err_cnt4 second", 32'(err_cnt4), 15);
        chk("sat locked4 two bad", 32'(locked4), 1);
        drive(1, 1, g[28], 0);
        drive(1, 1, g[29] ^ ALL, 1);
        chk("clr err_cnt", err_cnt, 0);
        chk("clr err_cnt4", 32'(err_cnt4), 0);
        chk("clr word_cnt4", 32'(word_cnt4), 0);
        chk("clr err_word4", 32'(err_word4), 1);
        chk("clr err_bits4", 32'(err_bits4), 24);
        chk("clr locked4", 32'(locked4), 1);
        drive(0, 1, g[30], 0);
        chk("rst locked4", 32'(locked4), 0);
        chk("rst err_word4", 32'(err_word4), 0);
        chk("rst err_bits4", 32'(err_bits4), 0);
        chk("rst err_cnt4", 32'(err_cnt4), 0);
        chk("rst word_cnt4", 32'(word_cnt4), 0);
        for (int k = 1; k <= 4; k++) drive(1, 1, g[k], 0);
        chk("relock before5", 32'(locked4), 0);
        drive(1, 1, g[5], 0);
        chk("relock after5", 32'(locked4), 1);
        chk("relock after5 w32", 32'(locked), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
